lane_packer: RTL and testbench

Receive-side counterpart to the width-mirroring I/O test harness: accepts a stream of narrow lanes (default 8 bits) and packs them into one wide word (default 128 bits) for the wide output port. Uses valid/ready handshakes on both sides, with full backpressure. It is the sequential packing stage between a byte-wide producer and a 128-bit consumer in the simulation test design.

---
 rtl/lane_packer.sv | 86 ++++++++
 tb/tb_lane_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_packer.sv
// Packs a stream of narrow lanes, little-endian, into one wide word with valid/ready on both sides.
// Define LANE_PACKER_LAST_EN to add the in_last port, which closes a word early.
module lane_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 128,
  localparam int BEATS    = OUT_WIDTH / IN_WIDTH,
  localparam int CW       = $clog2(BEATS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef LANE_PACKER_LAST_EN
  input  logic                 in_last,
`endif
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_count
);

  localparam int IW = CW - 1;
  localparam logic [0:0]    S_FILL   = 1'b0;
  localparam logic [0:0]    S_HOLD   = 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

  logic [0:0]           r_state;
  logic [IW-1:0]        r_idx;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic [CW-1:0]        r_out_count;

  logic                 w_accept;
  logic                 w_release;
  logic                 w_last;
  logic                 w_close;
  logic [OUT_WIDTH-1:0] w_word;

`ifdef LANE_PACKER_LAST_EN
  assign w_last = in_last;
`else
  assign w_last = 1'b0;
`endif

  // The held word is the only thing that can stall the input side.
  assign out_valid = (r_state == S_HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;
  assign w_close   = w_accept && (w_last || (r_idx == LAST_IDX));

  always_comb begin
    w_word = r_acc;
    w_word[int'(r_idx) * IN_WIDTH +: IN_WIDTH] = in_data;
  end

  // A closing accept wins over a release, so a word closing in the release cycle stays valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (w_close) begin
      r_out_data  <= w_word;
      r_out_count <= CW'(r_idx) + CW'(1);
      r_acc       <= '0;
      r_idx       <= '0;
      r_state     <= S_HOLD;
    end else begin
      if (w_accept) begin
        r_acc <= w_word;
        r_idx <= r_idx + IW'(1);
      end
      if (w_release) begin
        r_state <= S_FILL;
      end
    end
  end

endmodule

// File: tb/tb_lane_packer.sv
// Randomized bench for lane_packer checked against a queue-based packing model.
// Define LANE_PACKER_LAST_EN to also exercise early word close.
module tb_lane_packer;

  localparam int IN_WIDTH  = 8;
  localparam int OUT_WIDTH = 128;
  localparam int BEATS     = 16;
  localparam int CW        = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
`ifdef LANE_PACKER_LAST_EN
  logic                 in_last;
`endif
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_count;

  int n_vec = 0;
  int n_err = 0;

  logic [IN_WIDTH-1:0]  lane_q[$];
  logic [OUT_WIDTH-1:0] expd_q[$];
  int                   expc_q[$];

  logic                 s_ready, s_valid;
  logic [OUT_WIDTH-1:0] s_data;
  logic [CW-1:0]        s_count;
  logic                 e_ready, e_valid;
  logic [OUT_WIDTH-1:0] e_data;
  logic [CW-1:0]        e_count;

  lane_packer #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef LANE_PACKER_LAST_EN
    .in_last   (in_last),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // A word is the accepted lanes summed at increasing byte offsets, closed at BEATS lanes or on last.
  function automatic void model_accept(input logic [IN_WIDTH-1:0] d, input logic l);
    logic [OUT_WIDTH-1:0] w;
    w = '0;
    lane_q.push_back(d);
    if (lane_q.size() == BEATS || l) begin
      for (int k = 0; k < lane_q.size(); k++)
        w = w | (OUT_WIDTH'(lane_q[k]) << (IN_WIDTH * k));
      expd_q.push_back(w);
      expc_q.push_back(lane_q.size());
      lane_q.delete();
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef LANE_PACKER_LAST_EN
    in_last = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lane_q.delete(); expd_q.delete(); expc_q.delete();
  endtask

  // Drives one cycle, samples the DUT, and records what the model expects for that cycle.
  task automatic drive_cycle(input logic v, input logic [IN_WIDTH-1:0] d, input logic l, input logic ordy);
    in_valid = v; in_data = d; out_ready = ordy;
`ifdef LANE_PACKER_LAST_EN
    in_last = l;
`endif
    #1;
    s_ready = in_ready; s_valid = out_valid; s_data = out_data; s_count = out_count;
    e_valid = (expd_q.size() > 0);
    e_ready = !e_valid || ordy;
    e_data  = e_valid ? expd_q[0] : '0;
    e_count = e_valid ? CW'(expc_q[0]) : '0;
    if (e_valid && ordy) begin
      void'(expd_q.pop_front());
      void'(expc_q.pop_front());
    end
    if (v && e_ready) model_accept(d, l);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_vec++; if (out_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", out_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_sequential();
    for (int c = 0; c < 18; c++) begin
      drive_cycle(c < 16, IN_WIDTH'(c), 1'b0, 1'b1);
      n_vec++; if (s_valid !== (c == 16)) begin n_err++; $display("FAIL seq_valid c=%0d: got %b expected %b", c, s_valid, (c == 16)); end
      n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL seq_ready c=%0d: got %b expected 1", c, s_ready); end
      if (c == 16) begin
        n_vec++; if (s_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin n_err++; $display("FAIL seq_data: got %h expected 0f0e0d0c0b0a09080706050403020100", s_data); end
        n_vec++; if (s_count !== 5'd16) begin n_err++; $display("FAIL seq_count: got %0d expected 16", s_count); end
      end
    end
  endtask

  task automatic test_stream();
    int released = 0;
    for (int c = 0; c < 50; c++) begin
      drive_cycle(c < 48, IN_WIDTH'($urandom), 1'b0, 1'b1);
      if (s_valid === 1'b1) released++;
      n_vec++; if (s_valid !== e_valid) begin n_err++; $display("FAIL stream_valid c=%0d: got %b expected %b", c, s_valid, e_valid); end
      n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready c=%0d: got %b expected 1", c, s_ready); end
      if (e_valid) begin
        n_vec++; if (s_data !== e_data) begin n_err++; $display("FAIL stream_data c=%0d: got %h expected %h", c, s_data, e_data); end
        n_vec++; if (s_count !== e_count) begin n_err++; $display("FAIL stream_count c=%0d: got %0d expected %0d", c, s_count, e_count); end
      end
    end
    n_vec++; if (released != 3) begin n_err++; $display("FAIL stream_words: got %0d expected 3", released); end
  endtask

  task automatic test_backpressure();
    logic [OUT_WIDTH-1:0] held;
    for (int c = 0; c < 16; c++) begin
      drive_cycle(1'b1, IN_WIDTH'($urandom), 1'b0, 1'b1);
      n_vec++; if (s_valid !== e_valid) begin n_err++; $display("FAIL bp_fill_valid c=%0d: got %b expected %b", c, s_valid, e_valid); end
    end
    held = expd_q.size() > 0 ? expd_q[0] : '0;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b1, 8'h55, 1'b0, 1'b0);
      n_vec++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready c=%0d: got %b expected 0", c, s_ready); end
      n_vec++; if (s_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c=%0d: got %b expected 1", c, s_valid); end
      n_vec++; if (s_data !== held) begin n_err++; $display("FAIL bp_stable c=%0d: got %h expected %h", c, s_data, held); end
    end
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    n_vec++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", s_ready); end
    n_vec++; if (s_data !== e_data) begin n_err++; $display("FAIL bp_release_data: got %h expected %h", s_data, e_data); end
    for (int c = 0; c < 16; c++) begin
      drive_cycle(c < 15, IN_WIDTH'($urandom), 1'b0, 1'b1);
      n_vec++; if (s_valid !== e_valid) begin n_err++; $display("FAIL bp_next_valid c=%0d: got %b expected %b", c, s_valid, e_valid); end
    end
    n_vec++; if (s_data[7:0] !== 8'hAA) begin n_err++; $display("FAIL bp_lane0: got %h expected aa", s_data[7:0]); end
    n_vec++; if (s_data !== e_data) begin n_err++; $display("FAIL bp_next_data: got %h expected %h", s_data, e_data); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midword();
    for (int c = 0; c < 7; c++) drive_cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    do_reset();
    for (int c = 0; c < 17; c++) begin
      drive_cycle(c < 16, IN_WIDTH'(8'h10 + c), 1'b0, 1'b1);
      n_vec++; if (s_valid !== (c == 16)) begin n_err++; $display("FAIL rst_valid c=%0d: got %b expected %b", c, s_valid, (c == 16)); end
    end
    n_vec++; if (s_data !== 128'h1F1E1D1C1B1A19181716151413121110) begin n_err++; $display("FAIL rst_data: got %h expected 1f1e1d1c1b1a19181716151413121110", s_data); end
    n_vec++; if (s_count !== 5'd16) begin n_err++; $display("FAIL rst_count: got %0d expected 16", s_count); end
  endtask

  task automatic test_random();
    logic l;
    for (int c = 0; c < 300; c++) begin
      l = 1'b0;
`ifdef LANE_PACKER_LAST_EN
      l = ($urandom_range(0, 5) == 0);
`endif
      drive_cycle($urandom_range(0, 3) != 0, IN_WIDTH'($urandom), l, $urandom_range(0, 2) != 0);
      n_vec++; if (s_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, s_valid, e_valid); end
      n_vec++; if (s_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready c=%0d: got %b expected %b", c, s_ready, e_ready); end
      if (e_valid) begin
        n_vec++; if (s_data !== e_data) begin n_err++; $display("FAIL rnd_data c=%0d: got %h expected %h", c, s_data, e_data); end
        n_vec++; if (s_count !== e_count) begin n_err++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, s_count, e_count); end
      end
    end
  endtask

`ifdef LANE_PACKER_LAST_EN
  task automatic test_last_short();
    do_reset();
    drive_cycle(1'b1, 8'h11, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h22, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'h33, 1'b1, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    n_vec++; if (s_valid !== 1'b1) begin n_err++; $display("FAIL last_valid: got %b expected 1", s_valid); end
    n_vec++; if (s_data !== 128'h332211) begin n_err++; $display("FAIL last_data: got %h expected 332211", s_data); end
    n_vec++; if (s_count !== 5'd3) begin n_err++; $display("FAIL last_count: got %0d expected 3", s_count); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL last_fall: got %b expected 0", s_valid); end
  endtask

  task automatic test_last_overlap();
    do_reset();
    for (int c = 0; c < 16; c++) drive_cycle(1'b1, IN_WIDTH'($urandom), 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h5A, 1'b1, 1'b1);
    n_vec++; if (s_data !== e_data) begin n_err++; $display("FAIL ovl_release_data: got %h expected %h", s_data, e_data); end
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    n_vec++; if (s_valid !== 1'b1) begin n_err++; $display("FAIL ovl_valid: got %b expected 1", s_valid); end
    n_vec++; if (s_data !== 128'h5A) begin n_err++; $display("FAIL ovl_data: got %h expected 5a", s_data); end
    n_vec++; if (s_count !== 5'd1) begin n_err++; $display("FAIL ovl_count: got %0d expected 1", s_count); end
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL ovl_fall: got %b expected 0", s_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stream();
    test_backpressure();
    test_reset_midword();
    test_random();
`ifdef LANE_PACKER_LAST_EN
    test_last_short();
    test_last_overlap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
